// File: rtl/sw_pkg.sv
// Shared constants for the DIP-switch input path: the debouncer and the switch reader.
package sw_pkg;

  localparam int unsigned SW_WIDTH          = 64;
  localparam logic        SW_IDLE_LEVEL     = 1'b1;
  localparam int unsigned SW_TICK_DIV       = 50000;
  localparam int unsigned SW_STABLE_SAMPLES = 4;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, sample history and debounced level register.
// The toggle output is combinational and is meant to be registered by the caller.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic tog
);

  logic                      sync1_q;
  logic                      sync2_q;
  logic [STABLE_SAMPLES-2:0] hist_q;
  logic [STABLE_SAMPLES-1:0] nxt;
  logic                      level_q;
  logic                      level_d;

  always_comb begin
    nxt     = {hist_q, sync2_q};
    level_d = level_q;
    if (tick) begin
      if (&nxt) begin
        level_d = 1'b1;
      end else if (~|nxt) begin
        level_d = 1'b0;
      end
    end
  end

  assign tog   = level_d ^ level_q;
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= SW_IDLE_LEVEL;
      sync2_q <= SW_IDLE_LEVEL;
      hist_q  <= {(STABLE_SAMPLES - 1){SW_IDLE_LEVEL}};
      level_q <= SW_IDLE_LEVEL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (tick) begin
        hist_q <= nxt[STABLE_SAMPLES-2:0];
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switch pins with a shared sample tick and reports every
// debounced transition as a sticky mask and a one-cycle pulse.
module switch_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH          = SW_WIDTH,
  parameter int unsigned TICK_DIV       = SW_TICK_DIV,
  parameter int unsigned STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clear,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] change_mask,
  output logic             change_pulse
);

  localparam int unsigned CntW = $clog2(TICK_DIV + 1);

  logic [CntW-1:0]  cnt_q;
  logic             tick;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] change_mask_q;
  logic             change_pulse_q;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (sw_raw[i]),
      .level(sw_out[i]),
      .tog  (tog[i])
    );
  end

  // A toggle landing in the same cycle as clear must survive the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      change_mask_q  <= '0;
      change_pulse_q <= 1'b0;
    end else begin
      change_mask_q  <= (clear ? '0 : change_mask_q) | tog;
      change_pulse_q <= |tog;
    end
  end

  assign change_mask  = change_mask_q;
  assign change_pulse = change_pulse_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=64.
module tb_switch_debouncer;

  localparam int unsigned Width    = 64;
  localparam int unsigned TickDiv  = 4;
  localparam int unsigned Stable   = 3;

  logic             clk;
  logic             rst;
  logic [Width-1:0] sw_raw;
  logic             clear;
  logic [Width-1:0] sw_out;
  logic [Width-1:0] change_mask;
  logic             change_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;
  int pulse_cnt = 0;

  switch_debouncer #(
    .WIDTH         (Width),
    .TICK_DIV      (TickDiv),
    .STABLE_SAMPLES(Stable)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .clear       (clear),
    .sw_out      (sw_out),
    .change_mask (change_mask),
    .change_pulse(change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; sample ticks land on edges where ecount % 4 == 0.
  always @(posedge clk) begin
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;
    pulse_cnt <= pulse_cnt + int'(change_pulse);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 8; i++) begin
      if (ecount % TickDiv == 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p0;
    int bad;
    bit done;

    // 1 Reset and release with all switches on
    rst    = 1'b0;
    sw_raw = '0;
    clear  = 1'b0;
    step(2);
    check_eq("rst_sw_out", sw_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("rst_mask", change_mask, 64'h0);
    check_eq("rst_pulse", 64'(change_pulse), 64'h0);
    rst = 1'b1;
    step(11);
    check_eq("rel_hold_e11", sw_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    check_eq("rel_fall_e12", sw_out, 64'h0);
    check_eq("rel_pulse", 64'(change_pulse), 64'h1);
    check_eq("rel_mask", change_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    check_eq("rel_pulse_off", 64'(change_pulse), 64'h0);

    // Return all switches to off, then clear the mask
    sw_raw = '1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1);
      if (sw_out == 64'hFFFF_FFFF_FFFF_FFFF) done = 1'b1;
    end
    check_eq("rise_all", sw_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("clear_all", change_mask, 64'h0);

    // 2 Clean press on bit0
    align();
    p0 = pulse_cnt;
    sw_raw[0] = 1'b0;
    step(11);
    check_eq("press_hold", 64'(sw_out[0]), 64'h1);
    step(1);
    check_eq("press_out", sw_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("press_mask", change_mask, 64'h1);
    step(4);
    check_eq("press_npulse", 64'(pulse_cnt - p0), 64'h1);

    // 3 Bounce on bit5 never reaches three equal samples
    bad = 0;
    p0  = pulse_cnt;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_raw[5] = ~sw_raw[5];
      step(1);
      if (sw_out[5] !== 1'b1) bad++;
    end
    sw_raw[5] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (sw_out[5] !== 1'b1) bad++;
    end
    check_eq("bounce_level", 64'(bad), 64'h0);
    check_eq("bounce_pulse", 64'(pulse_cnt - p0), 64'h0);

    // 4 Clear colliding with a bit1 toggle
    check_eq("coll_pre_mask", change_mask, 64'h1);
    align();
    sw_raw[1] = 1'b0;
    step(11);
    check_eq("coll_hold", 64'(sw_out[1]), 64'h1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("coll_mask", change_mask, 64'h2);
    check_eq("coll_out", 64'(sw_out[1]), 64'h0);
    check_eq("coll_pulse", 64'(change_pulse), 64'h1);
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("clear_idle", change_mask, 64'h0);

    // 5 Reset after two of three low samples on bit3
    align();
    sw_raw[3] = 1'b0;
    step(8);
    check_eq("mid_two_samples", 64'(sw_out[3]), 64'h1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_eq("mid_rst_out", sw_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("mid_rst_mask", change_mask, 64'h0);
    check_eq("mid_rst_pulse", 64'(change_pulse), 64'h0);
    step(11);
    check_eq("mid_fresh_hold", sw_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    check_eq("mid_fall", sw_out, 64'hFFFF_FFFF_FFFF_FFF4);
    check_eq("mid_mask", change_mask, 64'h0B);
    check_eq("mid_pulse", 64'(change_pulse), 64'h1);

    // 6 Top byte falls together
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("wide_pre_mask", change_mask, 64'h0);
    align();
    p0 = pulse_cnt;
    sw_raw[63:56] = 8'h00;
    step(11);
    check_eq("wide_hold", 64'(sw_out[63:56]), 64'hFF);
    check_eq("wide_hold_pulse", 64'(change_pulse), 64'h0);
    step(1);
    check_eq("wide_out", sw_out, 64'h00FF_FFFF_FFFF_FFF4);
    check_eq("wide_mask", change_mask, 64'hFF00_0000_0000_0000);
    check_eq("wide_pulse", 64'(change_pulse), 64'h1);
    step(3);
    check_eq("wide_npulse", 64'(pulse_cnt - p0), 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
